// File: rtl/outbuf_drain.sv
// Output buffer for one systolic-array column: captures non-stallable result words into a
// circular FIFO, drains them over valid/ready and pulses done once a full tile has drained.
module outbuf_drain #(
   parameter int WORDLEN = 8,
   parameter int BUFSIZE = 8,
   parameter int TILELEN = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         in_valid,
   input  logic [WORDLEN-1:0]           din,
   output logic                         in_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WORDLEN-1:0]           dout,
   output logic [$clog2(BUFSIZE+1)-1:0] level,
   output logic                         busy,
   output logic                         done,
   output logic                         overflow
);

   localparam int PW = (BUFSIZE > 1) ? $clog2(BUFSIZE) : 1;
   localparam int LW = $clog2(BUFSIZE + 1);
   localparam int CW = $clog2(TILELEN + 1);

   localparam logic [LW-1:0] FULL_LVL = LW'(BUFSIZE);
   localparam logic [PW-1:0] LAST_PTR = PW'(BUFSIZE - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TILELEN - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TILELEN);

   typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      wptr_q, wptr_d;
   logic [PW-1:0]      rptr_q, rptr_d;
   logic [LW-1:0]      level_q, level_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;
   logic [WORDLEN-1:0] mem_q [BUFSIZE];

   logic full, empty, push, pop;

   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);
   assign push  = (state_q == COLLECT) && in_valid && !full;
   assign pop   = !empty && out_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = COLLECT;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         COLLECT: begin
            // A dropped word still counts toward the tile length.
            if (in_valid) begin
               if (full) ovf_d = 1'b1;
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
               if (cnt_q >= CNT_LAST) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (empty) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (push) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   // Storage is deliberately unreset; dout is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= din;
   end

   assign in_ready  = (state_q == COLLECT) && !full;
   assign out_valid = !empty;
   assign dout      = empty ? '0 : mem_q[rptr_q];
   assign level     = level_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_outbuf_drain.sv
// Bench for outbuf_drain: three instances (TILELEN 4/10/20) share inputs and are checked against
// a queue-based reference model every cycle, plus a vector table and directed corner sequences.
module tb_outbuf_drain;

   localparam int BS = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic [7:0] din;
   logic       out_ready;

   logic [2:0] in_ready_w, out_valid_w, busy_w, done_w, overflow_w;
   logic [7:0] dout_w  [3];
   logic [3:0] level_w [3];

   always #5 clk = ~clk;

   outbuf_drain #(.WORDLEN(8), .BUFSIZE(BS), .TILELEN(4)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .din(din),
      .in_ready(in_ready_w[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready),
      .dout(dout_w[0]), .level(level_w[0]), .busy(busy_w[0]), .done(done_w[0]),
      .overflow(overflow_w[0]));

   outbuf_drain #(.WORDLEN(8), .BUFSIZE(BS), .TILELEN(10)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .din(din),
      .in_ready(in_ready_w[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready),
      .dout(dout_w[1]), .level(level_w[1]), .busy(busy_w[1]), .done(done_w[1]),
      .overflow(overflow_w[1]));

   outbuf_drain #(.WORDLEN(8), .BUFSIZE(BS), .TILELEN(20)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .din(din),
      .in_ready(in_ready_w[2]), .out_valid(out_valid_w[2]), .out_ready(out_ready),
      .dout(dout_w[2]), .level(level_w[2]), .busy(busy_w[2]), .done(done_w[2]),
      .overflow(overflow_w[2]));

   // Reference model: phase 0=idle 1=collect 2=flush, buffered words in a queue.
   int         mst   [3];
   int         mcnt  [3];
   bit         movf  [3];
   bit         mdone [3];
   logic [7:0] mq    [3][$];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit         st;
      bit         iv;
      logic [7:0] d;
      bit         ordy;
      bit         e_ov;
      logic [7:0] e_dout;
      int         e_lvl;
      bit         e_busy;
      bit         e_done;
   } vec_t;

   function automatic int tl_of(input int k);
      return (k == 0) ? 4 : ((k == 1) ? 10 : 20);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mst[k] = 0; mcnt[k] = 0; movf[k] = 1'b0; mdone[k] = 1'b0;
         mq[k].delete();
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         int L;
         L = mq[k].size();
         mdone[k] = (mst[k] == 2) && (L == 0);
         if (L > 0 && out_ready) void'(mq[k].pop_front());
         case (mst[k])
            0: if (start) begin mst[k] = 1; mcnt[k] = 0; movf[k] = 1'b0; end
            1: if (in_valid) begin
                  if (L == BS) movf[k] = 1'b1;
                  else mq[k].push_back(din);
                  mcnt[k]++;
                  if (mcnt[k] == tl_of(k)) mst[k] = 2;
               end
            default: if (L == 0) mst[k] = 0;
         endcase
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 3; k++) begin
         string p;
         int    sz;
         p  = $sformatf("k%0d.", k);
         sz = mq[k].size();
         chk({p, "out_valid"}, out_valid_w[k], (sz > 0) ? 1 : 0);
         chk({p, "dout"},      dout_w[k],      (sz > 0) ? int'(mq[k][0]) : 0);
         chk({p, "level"},     level_w[k],     sz);
         chk({p, "busy"},      busy_w[k],      (mst[k] != 0) ? 1 : 0);
         chk({p, "done"},      done_w[k],      mdone[k] ? 1 : 0);
         chk({p, "overflow"},  overflow_w[k],  movf[k] ? 1 : 0);
         chk({p, "in_ready"},  in_ready_w[k],  (mst[k] == 1 && sz < BS) ? 1 : 0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   function automatic bit all_quiet();
      for (int k = 0; k < 3; k++)
         if (mst[k] != 0 || mq[k].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic settle();
      int n;
      n = 0;
      start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      while (!all_quiet() && n < 200) begin
         din = 8'($urandom);
         tick();
         n++;
      end
      if (n >= 200) chk("settle_timeout", 1, 0);
      in_valid = 1'b0;
      tick();
   endtask

   initial begin
      vec_t       tbl [8];
      logic [7:0] pushed [$];
      logic [7:0] got [$];
      int         n, sent, lvl;

      tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 1, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 8'h44, 1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1};
      tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0};

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; din = 8'h00; out_ready = 1'b0;
      model_reset();
      #2 compare_all();
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Basic tile on the TILELEN=4 instance, table driven.
      settle();
      for (int i = 0; i < 8; i++) begin
         start = tbl[i].st; in_valid = tbl[i].iv; din = tbl[i].d; out_ready = tbl[i].ordy;
         tick();
         chk($sformatf("t2.out_valid[%0d]", i), out_valid_w[0], tbl[i].e_ov);
         chk($sformatf("t2.dout[%0d]", i),      dout_w[0],      tbl[i].e_dout);
         chk($sformatf("t2.level[%0d]", i),     level_w[0],     tbl[i].e_lvl);
         chk($sformatf("t2.busy[%0d]", i),      busy_w[0],      tbl[i].e_busy);
         chk($sformatf("t2.done[%0d]", i),      done_w[0],      tbl[i].e_done);
      end

      // Reset asserted mid-cycle with two words buffered.
      settle();
      start = 1'b1; tick(); start = 1'b0;
      in_valid = 1'b1; out_ready = 1'b0;
      din = 8'hA1; tick();
      din = 8'hA2; tick();
      in_valid = 1'b0;
      chk("t1.level_before", level_w[0], 2);
      #1 rst = 1'b1;
      #1 model_reset();
      chk("t1.out_valid", out_valid_w[0], 0);
      chk("t1.level",     level_w[0],     0);
      chk("t1.busy",      busy_w[0],      0);
      chk("t1.done",      done_w[0],      0);
      chk("t1.overflow",  overflow_w[0],  0);
      chk("t1.dout",      dout_w[0],      0);
      compare_all();
      #1 rst = 1'b0;
      tick(); tick();
      chk("t1.no_done", done_w[0], 0);

      // Full / overflow on the TILELEN=10 instance.
      settle();
      out_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      in_valid = 1'b1;
      for (int i = 1; i <= 10; i++) begin din = 8'(i); tick(); end
      in_valid = 1'b0;
      chk("t3.level_full", level_w[1],    8);
      chk("t3.in_ready",   in_ready_w[1], 0);
      chk("t3.overflow",   overflow_w[1], 1);
      chk("t3.busy",       busy_w[1],     1);
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("t3.dout[%0d]", i), dout_w[1], i);
         tick();
      end
      chk("t3.level_empty", level_w[1], 0);
      chk("t3.done_early",  done_w[1],  0);
      tick();
      chk("t3.done",        done_w[1],     1);
      chk("t3.busy_fall",   busy_w[1],     0);
      chk("t3.ovf_sticky",  overflow_w[1], 1);
      start = 1'b1; tick(); start = 1'b0;
      chk("t3.ovf_cleared", overflow_w[1], 0);

      // Simultaneous push/pop on the TILELEN=20 instance.
      settle();
      start = 1'b1; tick(); start = 1'b0;
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin din = 8'hA0 + 8'(i); tick(); end
      chk("t5.level8", level_w[2], 8);
      din = 8'hEE; out_ready = 1'b1; tick();
      chk("t5.level7",   level_w[2],    7);
      chk("t5.overflow", overflow_w[2], 1);
      chk("t5.dout_a1",  dout_w[2],     8'hA1);
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("t5.level1",   level_w[2], 1);
      chk("t5.dout_a7",  dout_w[2],  8'hA7);
      in_valid = 1'b1; din = 8'h5A; tick();
      in_valid = 1'b0;
      chk("t5.level_hold", level_w[2], 1);
      chk("t5.dout_5a",    dout_w[2],  8'h5A);

      // Ignored events: in_valid in IDLE, start during COLLECT.
      settle();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin din = 8'($urandom); tick(); end
      chk("t6.idle_level", level_w[0],    0);
      chk("t6.idle_ovf",   overflow_w[0], 0);
      chk("t6.idle_busy",  busy_w[0],     0);
      in_valid = 1'b0; out_ready = 1'b1;
      start = 1'b1; tick();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin din = 8'($urandom); tick(); end
      chk("t6.collect_ready", in_ready_w[0], 1);
      chk("t6.collect_busy",  busy_w[0],     1);
      start = 1'b0; din = 8'($urandom); tick();
      in_valid = 1'b0;
      chk("t6.flush_ready", in_ready_w[0], 0);
      chk("t6.flush_busy",  busy_w[0],     1);
      n = 0;
      do begin tick(); n++; end while (!done_w[0] && n < 10);
      chk("t6.done_latency", n, 2);

      // Wrap: 20 words through the depth-8 FIFO with random back-pressure.
      settle();
      start = 1'b1; tick(); start = 1'b0;
      sent = 0; n = 0;
      while (n < 500 && !(sent == 20 && mst[2] == 0)) begin
         lvl = mq[2].size();
         in_valid  = (sent < 20) && (lvl < 3) && ($urandom_range(3, 0) != 0);
         out_ready = (sent >= 20) ? 1'b1 : ((lvl >= 2) ? 1'($urandom) : 1'b0);
         din = 8'($urandom);
         if (in_valid) begin pushed.push_back(din); sent++; end
         if (out_valid_w[2] && out_ready) got.push_back(dout_w[2]);
         tick();
         n++;
      end
      in_valid = 1'b0;
      if (n >= 500) chk("t4.timeout", 1, 0);
      chk("t4.count", got.size(), 20);
      for (int i = 0; i < 20 && i < got.size(); i++)
         chk($sformatf("t4.word[%0d]", i), got[i], pushed[i]);
      chk("t4.overflow", overflow_w[2], 0);

      // Free-running random traffic with occasional asynchronous resets.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(63, 0) == 0) begin
            #1 rst = 1'b1;
            #1 model_reset();
            compare_all();
            #1 rst = 1'b0;
         end
         start     = ($urandom_range(7, 0) == 0);
         in_valid  = 1'($urandom);
         din       = 8'($urandom);
         out_ready = ($urandom_range(2, 0) != 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
